// File: rtl/cp0_pkg.sv
// Shared CP0 register addresses, SR/Cause field positions and exception codes.
// Used by cp0_ext and by the optional cp0_timer (built when CP0_EXT_TIMER_EN is defined).
package cp0_pkg;

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_SR      = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;
  localparam logic [4:0] ADDR_PRID    = 5'd15;

  localparam int SR_IE        = 0;
  localparam int SR_EXL       = 1;
  localparam int SR_IM_LO     = 10;
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_TI     = 30;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_BP   = 5'd9,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  // A delay-slot victim restarts at its branch, one word earlier.
  function automatic logic [31:0] victim_epc(input logic [31:0] vpc, input logic bd);
    logic [31:0] pc;
    pc = bd ? (vpc - 32'd4) : vpc;
    return {pc[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// Count/Compare timer with sticky TI flag; the whole module exists only when
// CP0_EXT_TIMER_EN is defined.
`ifdef CP0_EXT_TIMER_EN
module cp0_timer
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        wr_en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] count,
  output logic [31:0] compare,
  output logic        ti
);

  always_ff @(posedge clk) begin
    if (reset) begin
      count   <= '0;
      compare <= '0;
      ti      <= 1'b0;
    end else begin
      if (wr_en && addr == ADDR_COUNT)
        count <= wdata;
      else
        count <= count + 32'd1;

      if (wr_en && addr == ADDR_COMPARE)
        compare <= wdata;

      // A Compare write acknowledges the timer and beats a same-cycle match.
      if (wr_en && addr == ADDR_COMPARE)
        ti <= 1'b0;
      else if (count == compare && compare != 32'd0)
        ti <= 1'b1;
    end
  end

endmodule
`endif

// File: rtl/cp0_ext.sv
// Minimal CP0: SR, Cause, EPC, PRId, interrupt/exception entry and eret.
// Count/Compare timer is included only when CP0_EXT_TIMER_EN is defined.
module cp0_ext
  import cp0_pkg::*;
#(
  parameter int          NUM_HWINT = 6,
  parameter logic [31:0] PRID_VAL  = 32'h0000_2024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 en,
  input  logic [4:0]           CP0Add,
  input  logic [31:0]          CP0In,
  output logic [31:0]          CP0Out,
  input  logic [31:0]          VPC,
  input  logic                 BDIn,
  input  logic [4:0]           ExcCodeIn,
  input  logic [NUM_HWINT-1:0] HWInt,
  input  logic                 EXLClr,
  output logic [31:0]          EPCOut,
  output logic                 Req
);

  logic                 ie, exl, bd;
  logic [NUM_HWINT-1:0] im, ip, pend;
  logic [4:0]           exc_code;
  logic [31:0]          epc;
  logic                 ti, int_req, exc_req, wr_ok;

`ifdef CP0_EXT_TIMER_EN
  logic [31:0] count, compare;

  cp0_timer u_timer (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_ok),
    .addr    (CP0Add),
    .wdata   (CP0In),
    .count   (count),
    .compare (compare),
    .ti      (ti)
  );
`else
  assign ti = 1'b0;
`endif

  // The timer shares the highest hardware interrupt line.
  always_comb begin
    pend = HWInt;
    pend[NUM_HWINT-1] = HWInt[NUM_HWINT-1] | ti;
  end

  assign int_req = ie & |(pend & im);
  assign exc_req = |ExcCodeIn;
  assign Req     = ~EXLClr & ~exl & (int_req | exc_req);
  // mtc0 is the lowest-priority event and is dropped by eret or entry.
  assign wr_ok   = en & ~EXLClr & ~Req;
  assign EPCOut  = epc;

  always_ff @(posedge clk) begin
    if (reset) begin
      ie       <= 1'b0;
      exl      <= 1'b0;
      im       <= '0;
      ip       <= '0;
      bd       <= 1'b0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= pend;
      if (EXLClr) begin
        exl <= 1'b0;
      end else if (Req) begin
        exl      <= 1'b1;
        bd       <= BDIn;
        epc      <= victim_epc(VPC, BDIn);
        exc_code <= int_req ? 5'(EXC_INT) : ExcCodeIn;
      end else if (en) begin
        case (CP0Add)
          ADDR_SR: begin
            ie  <= CP0In[SR_IE];
            exl <= CP0In[SR_EXL];
            im  <= CP0In[SR_IM_LO +: NUM_HWINT];
          end
          ADDR_CAUSE: begin
            bd       <= CP0In[CAUSE_BD];
            exc_code <= CP0In[CAUSE_EXC_LO +: 5];
          end
          ADDR_EPC: epc <= {CP0In[31:2], 2'b00};
          default: ;
        endcase
      end
    end
  end

  always_comb begin
    CP0Out = '0;
    case (CP0Add)
      ADDR_SR: begin
        CP0Out[SR_IE]                   = ie;
        CP0Out[SR_EXL]                  = exl;
        CP0Out[SR_IM_LO +: NUM_HWINT]   = im;
      end
      ADDR_CAUSE: begin
        CP0Out[CAUSE_BD]                = bd;
        CP0Out[CAUSE_TI]                = ti;
        CP0Out[CAUSE_IP_LO +: NUM_HWINT] = ip;
        CP0Out[CAUSE_EXC_LO +: 5]       = exc_code;
      end
      ADDR_EPC:     CP0Out = epc;
      ADDR_PRID:    CP0Out = PRID_VAL;
`ifdef CP0_EXT_TIMER_EN
      ADDR_COUNT:   CP0Out = count;
      ADDR_COMPARE: CP0Out = compare;
`endif
      default:      CP0Out = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_ext.sv
// Self-checking bench for cp0_ext: directed scenarios then randomized traffic,
// all checked against a register-image reference model.
module tb_cp0_ext;

  localparam int          NH   = 6;
  localparam logic [31:0] PRID = 32'h0000_2024;
`ifdef CP0_EXT_TIMER_EN
  localparam bit TIMER = 1'b1;
`else
  localparam bit TIMER = 1'b0;
`endif
  localparam logic [31:0] SR_MASK    = 32'h0000_FC03;
  localparam logic [31:0] CAUSE_WMSK = 32'h8000_007C;

  logic          clk = 1'b0;
  logic          reset, en, BDIn, EXLClr, Req;
  logic [4:0]    CP0Add, ExcCodeIn;
  logic [31:0]   CP0In, CP0Out, VPC, EPCOut;
  logic [NH-1:0] HWInt;

  int checks = 0;
  int passes = 0;

  // Reference model: architectural register images.
  logic [31:0]   m_sr, m_cause, m_epc, m_count, m_compare;
  logic [NH-1:0] m_ip;
  logic          m_ti;

  cp0_ext #(.NUM_HWINT(NH), .PRID_VAL(PRID)) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .CP0Add    (CP0Add),
    .CP0In     (CP0In),
    .CP0Out    (CP0Out),
    .VPC       (VPC),
    .BDIn      (BDIn),
    .ExcCodeIn (ExcCodeIn),
    .HWInt     (HWInt),
    .EXLClr    (EXLClr),
    .EPCOut    (EPCOut),
    .Req       (Req)
  );

  always #5 clk = ~clk;

  function automatic logic [NH-1:0] m_pend();
    return HWInt | (NH'(m_ti) << (NH - 1));
  endfunction

  function automatic logic m_int_hit();
    return m_sr[0] && ((m_pend() & m_sr[10 +: NH]) != '0);
  endfunction

  function automatic logic m_req();
    return !EXLClr && !m_sr[1] && (m_int_hit() || ExcCodeIn != 5'd0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      5'd9:    return TIMER ? m_count : 32'd0;
      5'd11:   return TIMER ? m_compare : 32'd0;
      5'd12:   return m_sr;
      5'd13:   return m_cause | (32'(m_ti) << 30) | (32'(m_ip) << 10);
      5'd14:   return m_epc;
      5'd15:   return PRID;
      default: return 32'd0;
    endcase
  endfunction

  task automatic modelStep();
    logic          req, hit, wr, nti;
    logic [31:0]   ncount, ncompare;
    logic [NH-1:0] p;
    if (reset) begin
      m_sr = '0; m_cause = '0; m_epc = '0; m_count = '0; m_compare = '0;
      m_ip = '0; m_ti = 1'b0;
      return;
    end
    p   = m_pend();
    req = m_req();
    hit = m_int_hit();
    wr  = en && !EXLClr && !req;
    nti      = (wr && CP0Add == 5'd11) ? 1'b0 : (m_ti || (m_count == m_compare && m_compare != 0));
    ncount   = (wr && CP0Add == 5'd9) ? CP0In : m_count + 32'd1;
    ncompare = (wr && CP0Add == 5'd11) ? CP0In : m_compare;
    if (EXLClr) begin
      m_sr[1] = 1'b0;
    end else if (req) begin
      m_sr[1] = 1'b1;
      m_cause = (BDIn ? 32'h8000_0000 : 32'd0) | (32'(hit ? 5'd0 : ExcCodeIn) << 2);
      m_epc   = (BDIn ? VPC - 32'd4 : VPC) & ~32'd3;
    end else if (wr) begin
      if (CP0Add == 5'd12) m_sr = CP0In & SR_MASK;
      if (CP0Add == 5'd13) m_cause = CP0In & CAUSE_WMSK;
      if (CP0Add == 5'd14) m_epc = CP0In & ~32'd3;
    end
    m_ip = p;
    if (TIMER) begin
      m_ti = nti; m_count = ncount; m_compare = ncompare;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: check DUT against the model mid-cycle, then advance both.
  task automatic applyStimulus();
    #3;
    checkOutput("req", {31'b0, Req}, {31'b0, m_req()});
    checkOutput("epcout", EPCOut, m_epc);
    checkOutput("cp0out", CP0Out, m_read(CP0Add));
    modelStep();
    @(posedge clk);
    #1;
  endtask

  task automatic readCheck(input string tag, input logic [4:0] a, input logic [31:0] exp);
    CP0Add = a;
    #1;
    checkOutput(tag, CP0Out, exp);
  endtask

  task automatic idle();
    reset = 1'b0; en = 1'b0; CP0Add = '0; CP0In = '0; VPC = '0;
    BDIn = 1'b0; ExcCodeIn = '0; HWInt = '0; EXLClr = 1'b0;
  endtask

  initial begin
    logic [4:0] addrs[7];
    idle();
    reset = 1'b1;
    modelStep();
    @(posedge clk);
    #1;
    applyStimulus();
    reset = 1'b0;
    readCheck("rst_sr", 5'd12, 32'd0);
    readCheck("rst_cause", 5'd13, 32'd0);
    readCheck("rst_epc", 5'd14, 32'd0);
    checkOutput("rst_req", {31'b0, Req}, 32'd0);
    applyStimulus();

    // Interrupt entry
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_0401;
    applyStimulus();
    en = 1'b0; HWInt = 6'b000001; VPC = 32'h3000;
    #1;
    checkOutput("int_req", {31'b0, Req}, 32'd1);
    applyStimulus();
    HWInt = '0;
    readCheck("int_sr", 5'd12, 32'h0000_0403);
    readCheck("int_epc", 5'd14, 32'h0000_3000);
    readCheck("int_cause", 5'd13, 32'h0000_0400);
    EXLClr = 1'b1;
    applyStimulus();
    EXLClr = 1'b0;

    // Exception in delay slot
    ExcCodeIn = 5'd4; BDIn = 1'b1; VPC = 32'h3008;
    #1;
    checkOutput("exc_req", {31'b0, Req}, 32'd1);
    applyStimulus();
    ExcCodeIn = '0; BDIn = 1'b0;
    readCheck("exc_epc", 5'd14, 32'h0000_3004);
    readCheck("exc_cause", 5'd13, 32'h8000_0010);
    EXLClr = 1'b1;
    applyStimulus();
    EXLClr = 1'b0;

    // Interrupt beats exception; eret beats mtc0
    HWInt = 6'b000001; ExcCodeIn = 5'd10; VPC = 32'h3100;
    applyStimulus();
    HWInt = '0; ExcCodeIn = '0;
    readCheck("pri_cause", 5'd13, 32'h0000_0400);
    readCheck("pri_epc", 5'd14, 32'h0000_3100);
    EXLClr = 1'b1; en = 1'b1; CP0Add = 5'd12; CP0In = 32'd0;
    applyStimulus();
    EXLClr = 1'b0; en = 1'b0;
    readCheck("eret_sr", 5'd12, 32'h0000_0401);

    // EPC alignment, PRId, unimplemented, write masks
    en = 1'b1; CP0Add = 5'd14; CP0In = 32'h0000_3003;
    applyStimulus();
    en = 1'b0;
    readCheck("epc_align", 5'd14, 32'h0000_3000);
    readCheck("prid", 5'd15, PRID);
    readCheck("unimpl", 5'd20, 32'd0);
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'hFFFF_FFFF;
    applyStimulus();
    CP0Add = 5'd13;
    applyStimulus();
    en = 1'b0;
    readCheck("sr_mask", 5'd12, 32'h0000_FC03);
    readCheck("cause_mask", 5'd13, 32'h8000_007C);
    EXLClr = 1'b1;
    applyStimulus();
    EXLClr = 1'b0;

`ifdef CP0_EXT_TIMER_EN
    reset = 1'b1;
    applyStimulus();
    reset = 1'b0;
    en = 1'b1; CP0Add = 5'd12; CP0In = 32'h0000_8001;
    applyStimulus();
    CP0Add = 5'd11; CP0In = 32'd20;
    applyStimulus();
    CP0Add = 5'd9; CP0In = 32'd15;
    applyStimulus();
    en = 1'b0;
    readCheck("cnt_load", 5'd9, 32'd15);
    for (int i = 0; i < 5; i++) begin
      applyStimulus();
      checkOutput("ti_early", {31'b0, Req}, 32'd0);
    end
    applyStimulus();
    readCheck("ti_set", 5'd13, 32'h4000_0000);
    checkOutput("ti_req", {31'b0, Req}, 32'd1);
    applyStimulus();
    en = 1'b1; CP0Add = 5'd11; CP0In = 32'd20;
    applyStimulus();
    en = 1'b0; CP0Add = 5'd13;
    #1;
    checkOutput("ti_clr", {31'b0, CP0Out[30]}, 32'd0);
    en = 1'b1; CP0Add = 5'd9; CP0In = 32'hFFFF_FFFF;
    applyStimulus();
    en = 1'b0;
    readCheck("cnt_max", 5'd9, 32'hFFFF_FFFF);
    applyStimulus();
    readCheck("cnt_wrap", 5'd9, 32'd0);
    EXLClr = 1'b1;
    applyStimulus();
    EXLClr = 1'b0;
`else
    en = 1'b1; CP0Add = 5'd9; CP0In = 32'h1234;
    applyStimulus();
    CP0Add = 5'd11;
    applyStimulus();
    en = 1'b0;
    readCheck("no_count", 5'd9, 32'd0);
    readCheck("no_compare", 5'd11, 32'd0);
`endif

    // Reset aborts a concurrent exception entry
    ExcCodeIn = 5'd4; VPC = 32'h5000; reset = 1'b1;
    applyStimulus();
    reset = 1'b0; ExcCodeIn = '0;
    readCheck("rst_abort_epc", 5'd14, 32'd0);
    readCheck("rst_abort_sr", 5'd12, 32'd0);

    addrs[0] = 5'd9;  addrs[1] = 5'd11; addrs[2] = 5'd12; addrs[3] = 5'd13;
    addrs[4] = 5'd14; addrs[5] = 5'd15; addrs[6] = 5'd0;
    for (int i = 0; i < 400; i++) begin
      reset     = ($urandom_range(0, 63) == 0);
      en        = ($urandom_range(0, 3) == 0);
      CP0Add    = addrs[$urandom_range(0, 6)];
      if (CP0Add == 5'd0) CP0Add = 5'($urandom_range(0, 31));
      CP0In     = $urandom;
      if (CP0Add == 5'd12) CP0In[1] = ($urandom_range(0, 3) == 0);
      if (CP0Add == 5'd11) CP0In = m_count + 32'($urandom_range(1, 8));
      HWInt     = ($urandom_range(0, 3) == 0) ? NH'($urandom) : '0;
      ExcCodeIn = ($urandom_range(0, 7) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      EXLClr    = ($urandom_range(0, 5) == 0);
      BDIn      = 1'($urandom_range(0, 1));
      VPC       = $urandom;
      applyStimulus();
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/cp0_ext.md
CP0_EXT -- requirements
Module: cp0_ext

Interface
REQ-001 SHALL have parameter NUM_HWINT, default 6, number of external interrupt lines (legal 1..8).
REQ-002 SHALL have parameter PRID_VAL, default 32'h0000_2024, value read from PRId.
REQ-003 SHALL have port clk  input  1  clock; reset reset, synchronous, active-high; clock clk.
REQ-004 SHALL have port reset  input  1  synchronous active-high reset.
REQ-005 SHALL have port en  input  1  mtc0 write strobe.
REQ-006 SHALL have port CP0Add  input  5  register select for read and write.
REQ-007 SHALL have port CP0In  input  32  mtc0 write data.
REQ-008 SHALL have port CP0Out  output  32  mfc0 read data, combinational.
REQ-009 SHALL have port VPC  input  32  PC of the victim instruction.
REQ-010 SHALL have port BDIn  input  1  victim is in a delay slot.
REQ-011 SHALL have port ExcCodeIn  input  5  synchronous exception code (0 = none).
REQ-012 SHALL have port HWInt  input  NUM_HWINT  level-sensitive external interrupts.
REQ-013 SHALL have port EXLClr  input  1  eret commit.
REQ-014 SHALL have port EPCOut  output  32  current EPC.
REQ-015 SHALL have port Req  output  1  take-exception request, combinational.

Function
REQ-016 SHALL implement SR(12): IE=bit0, EXL=bit1, IM=bits[10+:NUM_HWINT]; all other bits read 0 and ignore writes.
REQ-017 SHALL implement Cause(13): BD=bit31, TI=bit30, IP=bits[10+:NUM_HWINT], ExcCode=bits[6:2]; other bits read 0.
REQ-018 SHALL implement EPC(14) with bits[1:0] forced to 0 on every update; PRId(15) read-only, returns PRID_VAL.
REQ-019 SHALL read 0 from any unimplemented address.
REQ-020 SHALL form the effective pending vector P = HWInt, with bit NUM_HWINT-1 ORed with TI when the timer is compiled in.
REQ-021 SHALL sample IP <= P every cycle that is not a reset, regardless of other events.
REQ-022 SHALL assert Req = !EXLClr & !EXL & ((IE & |(P & IM)) | ExcCodeIn!=0) in the same cycle.
REQ-023 SHALL resolve same-edge events in priority order: reset > EXLClr > interrupt > exception > mtc0 write.
REQ-024 On EXLClr SHALL clear EXL and ignore a concurrent mtc0 write and exception.
REQ-025 On interrupt entry SHALL set EXL, ExcCode=0, BD=BDIn, EPC=BDIn ? VPC-4 : VPC.
REQ-026 On exception entry SHALL set EXL, ExcCode=ExcCodeIn, BD and EPC as REQ-025.
REQ-027 SHALL make mtc0 writes take effect at the next clock edge; Cause writes alter only IM-independent writable fields BD/ExcCode (IP and TI not writable).
REQ-028 SHALL present EPCOut = EPC register, valid the cycle after entry.

Reset
REQ-029 SHALL on reset clear SR, Cause, EPC, Count, Compare and TI to 0; Req therefore 0 the cycle after reset unless ExcCodeIn!=0.
REQ-030 SHALL let reset abort any event in the same cycle (no EPC capture).

Configuration
REQ-031 SHALL compile the timer only when macro CP0_EXT_TIMER_EN is defined.
REQ-032 With CP0_EXT_TIMER_EN: Count(9) SHALL increment by 1 every non-reset cycle, wrapping 32'hFFFF_FFFF -> 0; an mtc0 to Count overrides the increment.
REQ-033 With CP0_EXT_TIMER_EN: TI SHALL set (sticky) the cycle after Count==Compare with Compare!=0; an mtc0 to Compare(11) SHALL clear TI, and a set and clear in the same cycle SHALL resolve to clear.
REQ-034 Without CP0_EXT_TIMER_EN: addresses 9 and 11 SHALL read 0, TI SHALL read 0, no counter logic exists.

Structure
REQ-035 SHALL place register-address constants (9,11,12,13,14,15), SR/Cause bit-position constants and ExcCode values in shared package cp0_pkg.
REQ-036 SHALL implement the timer as sub-module cp0_timer (Count, Compare, TI) instantiated only under CP0_EXT_TIMER_EN.

Verification
REQ-037 SR=32'h0000_0401 (IM0,IE), HWInt=6'b000001, VPC=32'h3000 -> Req=1 same cycle; next cycle EXL=1, EPC=32'h3000, ExcCode=0.
REQ-038 ExcCodeIn=5'd4, BDIn=1, VPC=32'h3008, no interrupt -> EPC=32'h3004, Cause[31]=1, ExcCode=4.
REQ-039 Interrupt and ExcCodeIn=10 same cycle -> ExcCode=0 (interrupt wins); then EXLClr=1 with en=1,CP0Add=12 -> EXL=0, SR write dropped.
REQ-040 Timer build: write Compare=32'd20, Count=32'd15, SR IM5+IE -> TI=1 and Req=1 six cycles later; write Compare -> TI=0.
REQ-041 Write EPC=32'h0000_3003 -> reads 32'h0000_3000; read address 15 -> PRID_VAL; read address 20 -> 0.
REQ-042 Count written 32'hFFFF_FFFF -> next cycle 0; reset asserted during exception entry -> EPC=0, EXL=0.
